matrix_operand_loader: RTL
==========================

Name: matrix_operand_loader

Overview:
- Upstream feeder for the matrix add/subtract stage.
- Accepts a byte-wide element stream from the HPS bridge and assembles two packed 5x5 signed 8-bit matrices, A then B.
- Captures the add/sub select and presents both matrices plus select to the arithmetic stage, holding them under a valid/ready handshake.

Parameters:
- N, 5, matrix dimension (N x N elements per matrix)
- ELEM_W, 8, element width in bits
- MAT_W, N*N*ELEM_W (200), packed matrix width; derived, not overridable

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- clear  input  1  synchronous abort: discard partial frame, clear frame_err
- in_valid  input  1  stream element valid
- in_ready  output  1  loader can accept an element
- in_data  input  ELEM_W  element value, row-major, A first then B
- in_op  input  1  sampled on the first beat of A: 0 = add, 1 = subtract
- in_last  input  1  marks the final element of B (beat N*N*2-1)
- mat_a  output  MAT_W  packed matrix A
- mat_b  output  MAT_W  packed matrix B
- mat_sel  output  1  captured op select, drives the add/sub Select
- mat_valid  output  1  mat_a/mat_b/mat_sel complete and stable
- mat_ready  input  1  consumer accepts the operand set
- frame_err  output  1  sticky framing error flag

Behaviour:
- Reset (async, rst=1): state=LOAD_A, idx=0, mat_a=0, mat_b=0, mat_sel=0, mat_valid=0, frame_err=0. in_ready=1 once rst deasserts.
- Beat = in_valid & in_ready on a clk edge.
- Packing: element (r,c) occupies bits [(r*N+c)*ELEM_W +: ELEM_W], so element 0 is at the LSBs. Unwritten bits keep their previous value.
- Element counter idx runs 0..N*N-1 within each matrix.
- LOAD_A: in_ready=1. Each beat writes in_data into mat_a slot idx.
  - On idx=0, in_op is latched into mat_sel.
  - On idx=N*N-1: idx->0, state->LOAD_B.
- LOAD_B: in_ready=1. Each beat writes mat_b slot idx.
  - in_last=1 on idx=N*N-1: state->HOLD, mat_valid=1 on the next cycle (one cycle after the final beat).
- HOLD: in_ready=0 and mat_valid=1. mat_a, mat_b and mat_sel are frozen.
  - When mat_valid & mat_ready: mat_valid->0, state->LOAD_A, idx=0 in the same edge.
  - No new element is accepted in the handoff cycle.
- Framing errors:
  - in_last=1 on any beat other than B idx N*N-1, or in_last=0 on B idx N*N-1.
  - Response: frame_err->1 (sticky), frame discarded, state->LOAD_A, idx=0, mat_valid stays 0.
  - Matrix registers may hold partial data but are never presented as valid.
- clear=1: overrides the stream in the same cycle.
  - state->LOAD_A, idx=0, frame_err->0, mat_valid->0, even in HOLD.
  - The beat in that cycle is ignored. in_ready is still driven by state.
- rst during a load or in HOLD: immediate return to reset values. Any in-flight beat is lost.
- mat_ready while not in HOLD has no effect.
- in_data is passed through with no arithmetic. Signedness is interpreted downstream.
- in_op on beats other than A idx 0 is ignored.

Decomposition:
- Shared package holds:
  - N, ELEM_W, MAT_W
  - state encoding LOAD_A=2'd0, LOAD_B=2'd1, HOLD=2'd2
  - OP_ADD=1'b0, OP_SUB=1'b1
  - a slot-offset function idx*ELEM_W
- One natural sub-module, packed_matrix_reg: an N*N-slot write-by-index register of ELEM_W elements.
  - Inputs: clk, rst, we, idx, din. Output: packed matrix.
  - Instantiated twice, for A and B.
- The FSM, counter and handshake stay in the top module.

Test Plan:
- Reset: assert rst mid-cycle asynchronously -> all outputs 0 immediately, in_ready=1 after release.
- Nominal add: stream A elements 1..25 with in_op=0 on the first beat, then B = 25 beats of 0xFF with in_last on the 50th, mat_ready=0. Required: mat_a[7:0]=0x01, mat_a[199:192]=0x19, mat_b all 0xFF, mat_sel=0, mat_valid=1 one cycle after beat 50, in_ready=0.
- Handshake/backpressure: hold mat_ready=0 for 10 cycles while in_valid=1 -> outputs stable, no beats accepted. Raise mat_ready for 1 cycle -> mat_valid=0 next cycle, in_ready=1. A second frame with in_op=1 yields mat_sel=1.
- Gapped stream: toggle in_valid randomly, 50% duty -> same packed result as the nominal test, mat_valid only after the 50th accepted beat.
- Framing errors:
  - in_last on beat 30 -> frame_err=1, mat_valid never asserts, next full frame loads correctly with frame_err still 1.
  - Missing in_last on beat 50 -> frame_err=1.
  - clear -> frame_err=0.
- Clear mid-frame and in HOLD: clear at A idx 12 -> idx restarts, the following 50-beat frame is correct. clear in HOLD -> mat_valid drops next cycle without mat_ready.

Source files
------------

// File: rtl/matrix_operand_loader_pkg.sv
// Shared sizing, FSM encoding and op-select codes for the matrix operand loader.
package matrix_operand_loader_pkg;

  localparam int N      = 5;
  localparam int ELEM_W = 8;
  localparam int SLOTS  = N * N;
  localparam int MAT_W  = SLOTS * ELEM_W;
  localparam int IDX_W  = $clog2(SLOTS);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } loaderState_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Bit offset of element slot idx; element 0 sits at the LSBs.
  function automatic int slotOffset(input logic [IDX_W-1:0] idx);
    return int'(idx) * ELEM_W;
  endfunction

endpackage

// File: rtl/packed_matrix_reg.sv
// N*N-slot packed element register, write-by-index; write lands one edge after we.
// No flow control: the owner decides when to write, unwritten slots hold their value.
module packed_matrix_reg
  import matrix_operand_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [ELEM_W-1:0] din,
  output logic [MAT_W-1:0]  mat
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mat <= '0;
    end else if (we && (idx < IDX_W'(SLOTS))) begin
      mat[slotOffset(idx) +: ELEM_W] <= din;
    end
  end

endmodule

// File: rtl/matrix_operand_loader.sv
// Assembles matrices A then B from a byte stream; mat_valid rises one cycle after the last beat.
// in_ready drops while the operand set is held; it is released by mat_ready, clear or rst.
module matrix_operand_loader
  import matrix_operand_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ELEM_W-1:0] in_data,
  input  logic              in_op,
  input  logic              in_last,
  output logic [MAT_W-1:0]  mat_a,
  output logic [MAT_W-1:0]  mat_b,
  output logic              mat_sel,
  output logic              mat_valid,
  input  logic              mat_ready,
  output logic              frame_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS - 1);

  loaderState_e     stateQ, stateD;
  logic [IDX_W-1:0] idxQ, idxD;
  logic             selQ, selD;
  logic             validQ, validD;
  logic             errQ, errD;
  logic             weA, weB;
  logic             beat;
  logic             lastSlot;

  assign in_ready  = (stateQ != HOLD);
  assign beat      = in_valid && in_ready;
  assign lastSlot  = (idxQ == LAST_IDX);
  assign mat_sel   = selQ;
  assign mat_valid = validQ;
  assign frame_err = errQ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= LOAD_A;
      idxQ   <= '0;
      selQ   <= OP_ADD;
      validQ <= 1'b0;
      errQ   <= 1'b0;
    end else begin
      stateQ <= stateD;
      idxQ   <= idxD;
      selQ   <= selD;
      validQ <= validD;
      errQ   <= errD;
    end
  end

  always_comb begin
    stateD = stateQ;
    idxD   = idxQ;
    selD   = selQ;
    validD = validQ;
    errD   = errQ;
    weA    = 1'b0;
    weB    = 1'b0;
    if (clear) begin
      stateD = LOAD_A;
      idxD   = '0;
      validD = 1'b0;
      errD   = 1'b0;
    end else begin
      case (stateQ)
        LOAD_A: begin
          if (beat) begin
            if (in_last) begin
              // in_last can never legally appear inside A: drop the frame.
              errD   = 1'b1;
              stateD = LOAD_A;
              idxD   = '0;
            end else begin
              weA = 1'b1;
              if (idxQ == '0) selD = in_op;
              if (lastSlot) begin
                idxD   = '0;
                stateD = LOAD_B;
              end else begin
                idxD = idxQ + 1'b1;
              end
            end
          end
        end
        LOAD_B: begin
          if (beat) begin
            if (in_last != lastSlot) begin
              errD   = 1'b1;
              stateD = LOAD_A;
              idxD   = '0;
            end else begin
              weB = 1'b1;
              if (lastSlot) begin
                idxD   = '0;
                stateD = HOLD;
                validD = 1'b1;
              end else begin
                idxD = idxQ + 1'b1;
              end
            end
          end
        end
        HOLD: begin
          if (mat_ready) begin
            validD = 1'b0;
            stateD = LOAD_A;
            idxD   = '0;
          end
        end
        default: begin
          stateD = LOAD_A;
          idxD   = '0;
          validD = 1'b0;
        end
      endcase
    end
  end

  packed_matrix_reg uMatA (
    .clk (clk),
    .rst (rst),
    .we  (weA),
    .idx (idxQ),
    .din (in_data),
    .mat (mat_a)
  );

  packed_matrix_reg uMatB (
    .clk (clk),
    .rst (rst),
    .we  (weB),
    .idx (idxQ),
    .din (in_data),
    .mat (mat_b)
  );

endmodule
